ps2_key_ctrl: RTL and testbench

//  Sequences raw PS/2 scan bytes from the receiver into keyboard events for the CPU.

---
 rtl/ps2_key_ctrl_pkg.sv | 81 ++++++++
 rtl/ps2_key_ctrl_fifo.sv | 70 +++++++
 rtl/ps2_key_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_ctrl_pkg.sv
// ============================================================================
// ps2_key_ctrl_pkg : scan-code constants, FSM/event types, scan-to-ASCII table
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ps2_key_ctrl_pkg;

   localparam logic [7:0] c_SC_EXT    = 8'hE0;
   localparam logic [7:0] c_SC_BRK    = 8'hF0;
   localparam logic [7:0] c_SC_LSHIFT = 8'h12;
   localparam logic [7:0] c_SC_RSHIFT = 8'h59;
   localparam logic [7:0] c_SC_CTRL   = 8'h14;
   localparam logic [7:0] c_SC_ALT    = 8'h11;
   localparam logic [7:0] c_SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kbd_state_e;

   // Decoded key plus the modifier state seen before that key was applied
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       ctrl;
      logic       alt;
      logic       shift;
      logic       caps;
   } key_req_t;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic       ctrl;
      logic       alt;
      logic       shift;
      logic       caps;
      logic       raw;
      logic       rsvd;
      logic [7:0] key;
   } kbd_event_t;

   function automatic logic is_ignored(input logic [7:0] code);
      return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
             (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
   endfunction

   // Returns {shifted, unshifted}; 16'h0000 marks a code with no ASCII mapping
   function automatic logic [15:0] scan_entry(input logic [7:0] code);
      logic [15:0] e;
      case (code)
         8'h1C: e = 16'h4161;  8'h32: e = 16'h4262;  8'h21: e = 16'h4363;
         8'h23: e = 16'h4464;  8'h24: e = 16'h4565;  8'h2B: e = 16'h4666;
         8'h34: e = 16'h4767;  8'h33: e = 16'h4868;  8'h43: e = 16'h4969;
         8'h3B: e = 16'h4A6A;  8'h42: e = 16'h4B6B;  8'h4B: e = 16'h4C6C;
         8'h3A: e = 16'h4D6D;  8'h31: e = 16'h4E6E;  8'h44: e = 16'h4F6F;
         8'h4D: e = 16'h5070;  8'h15: e = 16'h5171;  8'h2D: e = 16'h5272;
         8'h1B: e = 16'h5373;  8'h2C: e = 16'h5474;  8'h3C: e = 16'h5575;
         8'h2A: e = 16'h5676;  8'h1D: e = 16'h5777;  8'h22: e = 16'h5878;
         8'h35: e = 16'h5979;  8'h1A: e = 16'h5A7A;
         8'h45: e = 16'h2930;  8'h16: e = 16'h2131;  8'h1E: e = 16'h4032;
         8'h26: e = 16'h2333;  8'h25: e = 16'h2434;  8'h2E: e = 16'h2535;
         8'h36: e = 16'h5E36;  8'h3D: e = 16'h2637;  8'h3E: e = 16'h2A38;
         8'h46: e = 16'h2839;
         8'h29: e = 16'h2020;  8'h5A: e = 16'h0D0D;  8'h66: e = 16'h0808;
         8'h0D: e = 16'h0909;  8'h76: e = 16'h1B1B;  8'h4E: e = 16'h5F2D;
         8'h55: e = 16'h2B3D;  8'h41: e = 16'h3C2C;  8'h49: e = 16'h3E2E;
         8'h4A: e = 16'h3F2F;
         default: e = 16'h0000;
      endcase
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_ctrl_fifo.sv
// ============================================================================
// ps2_key_ctrl_fifo : synchronous event FIFO, push+pop in one cycle, sticky overflow
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_key_ctrl_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             clr_ovf_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             overflow_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      count_q;
   logic             ovf_q;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;
   logic             w_drop;

   assign empty_o    = (count_q == '0);
   assign w_full     = (count_q == (AW+1)'(DEPTH));
   assign w_pop      = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push while full still lands
   assign w_wr       = push_i && (!w_full || w_pop);
   assign w_drop     = push_i && w_full && !w_pop;
   assign rdata_o    = empty_o ? '0 : mem_q[rptr_q];
   assign overflow_o = ovf_q;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (w_wr)  wptr_q <= wptr_q + 1'b1;
         if (w_pop) rptr_q <= rptr_q + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (w_drop)         ovf_q <= 1'b1;
         else if (clr_ovf_i) ovf_q <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
// ============================================================================
// ps2_key_ctrl : PS/2 scan bytes -> prefix FSM, modifier tracking, ASCII event FIFO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_key_ctrl #(
   parameter int unsigned DEPTH      = 16,
   parameter bit          EMIT_BREAK = 1'b0,
   parameter int unsigned TIMEOUT    = 2**20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   input  logic        ren_i,
   input  logic        clr_ovf_i,
   output logic [15:0] data_o,
   output logic        ready_o,
   output logic        overflow_o,
   output logic        caps_led_o
);
   import ps2_key_ctrl_pkg::*;

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   kbd_state_e  state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d, caps_q, caps_d;
   key_req_t    req_q, req_d;
   logic        req_vld_q, req_vld_d;
   kbd_event_t  ev_q;
   logic        ev_vld_q;

   logic        w_key_fire, w_key_ext, w_key_brk;
   logic [15:0] w_entry;
   logic [7:0]  w_ascii;
   logic        w_letter, w_upper, w_raw;
   kbd_event_t  w_event;
   logic        w_empty;

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      w_key_fire = 1'b0;
      w_key_ext  = 1'b0;
      w_key_brk  = 1'b0;
      if (byte_valid_i) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (byte_data_i == c_SC_EXT)      state_d = ST_EXT;
               else if (byte_data_i == c_SC_BRK) state_d = ST_BRK;
               else if (!is_ignored(byte_data_i)) w_key_fire = 1'b1;
            end
            ST_EXT: begin
               if (byte_data_i == c_SC_BRK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  w_key_fire = 1'b1;
                  w_key_ext  = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_key_fire = 1'b1;
               w_key_brk  = 1'b1;
               state_d    = ST_IDLE;
            end
            default: begin
               w_key_fire = 1'b1;
               w_key_ext  = 1'b1;
               w_key_brk  = 1'b1;
               state_d    = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_comb begin
      shift_d   = shift_q;
      ctrl_d    = ctrl_q;
      alt_d     = alt_q;
      caps_d    = caps_q;
      req_vld_d = 1'b0;
      req_d     = '{code: byte_data_i, ext: w_key_ext, brk: w_key_brk,
                    ctrl: ctrl_q, alt: alt_q, shift: shift_q, caps: caps_q};
      if (w_key_fire) begin
         if (!w_key_ext && (byte_data_i == c_SC_LSHIFT || byte_data_i == c_SC_RSHIFT)) begin
            shift_d = !w_key_brk;
         end else if (byte_data_i == c_SC_CTRL) begin
            ctrl_d = !w_key_brk;
         end else if (byte_data_i == c_SC_ALT) begin
            alt_d = !w_key_brk;
         end else if (!w_key_ext && byte_data_i == c_SC_CAPS) begin
            if (!w_key_brk) caps_d = !caps_q;
         end else begin
            req_vld_d = !w_key_brk || EMIT_BREAK;
         end
      end
   end

   // Letters follow shift^caps; everything else follows shift only
   assign w_entry  = scan_entry(req_q.code);
   assign w_letter = (w_entry[7:0] >= 8'h61) && (w_entry[7:0] <= 8'h7A);
   assign w_upper  = w_letter ? (req_q.shift ^ req_q.caps) : req_q.shift;
   assign w_ascii  = w_upper ? w_entry[15:8] : w_entry[7:0];
   assign w_raw    = req_q.ext || (w_ascii == 8'h00);
   assign w_event  = '{brk: req_q.brk, ext: req_q.ext, ctrl: req_q.ctrl, alt: req_q.alt,
                       shift: req_q.shift, caps: req_q.caps, raw: w_raw, rsvd: 1'b0,
                       key: w_raw ? req_q.code : w_ascii};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmo_q     <= '0;
         shift_q   <= 1'b0;
         ctrl_q    <= 1'b0;
         alt_q     <= 1'b0;
         caps_q    <= 1'b0;
         req_q     <= '0;
         req_vld_q <= 1'b0;
         ev_q      <= '0;
         ev_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         shift_q   <= shift_d;
         ctrl_q    <= ctrl_d;
         alt_q     <= alt_d;
         caps_q    <= caps_d;
         req_q     <= req_d;
         req_vld_q <= req_vld_d;
         ev_q      <= w_event;
         ev_vld_q  <= req_vld_q;
      end
   end

   ps2_key_ctrl_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (ev_vld_q),
      .wdata_i    (ev_q),
      .pop_i      (ren_i),
      .clr_ovf_i  (clr_ovf_i),
      .rdata_o    (data_o),
      .empty_o    (w_empty),
      .overflow_o (overflow_o)
   );

   assign ready_o    = !w_empty;
   assign caps_led_o = caps_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
// ============================================================================
// tb_ps2_key_ctrl : directed + random stimulus against a queue-based keyboard model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_key_ctrl;
   localparam int unsigned DEPTH      = 4;
   localparam bit          EMIT_BREAK = 1'b1;
   localparam int unsigned TIMEOUT    = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        ren = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [15:0] data;
   logic        ready;
   logic        overflow;
   logic        caps_led;

   always #5 clk = ~clk;

   ps2_key_ctrl #(
      .DEPTH      (DEPTH),
      .EMIT_BREAK (EMIT_BREAK),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid_i (byte_valid),
      .byte_data_i  (byte_data),
      .ren_i        (ren),
      .clr_ovf_i    (clr_ovf),
      .data_o       (data),
      .ready_o      (ready),
      .overflow_o   (overflow),
      .caps_led_o   (caps_led)
   );

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] lo_tab [256];
   logic [7:0] hi_tab [256];
   logic [7:0] key_codes [$];

   typedef struct {
      logic [15:0] ev;
      int          due;
   } pend_t;

   pend_t       pipe [$];
   logic [15:0] mq [$];
   bit m_ext, m_brk, m_shift, m_ctrl, m_alt, m_caps, m_ovf;
   int m_idle = 0;
   int ecount = 0;

   function automatic void init_tables();
      logic [7:0] let_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                     8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                     8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
      logic [7:0] dig_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
      logic [7:0] x_codes [10] = '{8'h29,8'h5A,8'h66,8'h0D,8'h76,8'h4E,8'h55,8'h41,8'h49,8'h4A};
      logic [7:0] x_lo [10]    = '{8'h20,8'h0D,8'h08,8'h09,8'h1B,8'h2D,8'h3D,8'h2C,8'h2E,8'h2F};
      logic [7:0] x_hi [10]    = '{8'h20,8'h0D,8'h08,8'h09,8'h1B,8'h5F,8'h2B,8'h3C,8'h3E,8'h3F};
      string letters = "abcdefghijklmnopqrstuvwxyz";
      string digits  = "0123456789";
      string dig_sh  = ")!@#$%^&*(";
      for (int i = 0; i < 256; i++) begin
         lo_tab[i] = 8'h00;
         hi_tab[i] = 8'h00;
      end
      for (int i = 0; i < 26; i++) begin
         lo_tab[let_codes[i]] = letters[i];
         hi_tab[let_codes[i]] = letters[i] - 8'd32;
         key_codes.push_back(let_codes[i]);
      end
      for (int i = 0; i < 10; i++) begin
         lo_tab[dig_codes[i]] = digits[i];
         hi_tab[dig_codes[i]] = dig_sh[i];
         key_codes.push_back(dig_codes[i]);
         lo_tab[x_codes[i]] = x_lo[i];
         hi_tab[x_codes[i]] = x_hi[i];
         key_codes.push_back(x_codes[i]);
      end
      key_codes.push_back(8'h75);
      key_codes.push_back(8'h05);
   endfunction

   function automatic void model_key(input logic [7:0] b, input bit ext, input bit brk);
      logic [7:0] a;
      bit letter, up, raw;
      logic [15:0] ev;
      letter = (lo_tab[b] >= "a") && (lo_tab[b] <= "z");
      up     = letter ? (m_shift ^ m_caps) : m_shift;
      a      = up ? hi_tab[b] : lo_tab[b];
      raw    = ext || (a == 8'h00);
      ev     = {brk, ext, m_ctrl, m_alt, m_shift, m_caps, raw, 1'b0, raw ? b : a};
      if (!ext && (b == 8'h12 || b == 8'h59)) m_shift = !brk;
      else if (b == 8'h14) m_ctrl = !brk;
      else if (b == 8'h11) m_alt = !brk;
      else if (!ext && b == 8'h58) begin
         if (!brk) m_caps = !m_caps;
      end else if (!brk || EMIT_BREAK) begin
         pipe.push_back('{ev, ecount + 2});
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      bit ign;
      ign = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE) ||
            (b == 8'h00) || (b == 8'hFF);
      if (!m_ext && !m_brk) begin
         if (b == 8'hE0)      m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else if (!ign)       model_key(b, 1'b0, 1'b0);
      end else if (m_ext && !m_brk && b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         model_key(b, m_ext, m_brk);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   always @(posedge clk) begin
      bit push, pop, drop;
      ecount++;
      if (rst) begin
         pipe.delete();
         mq.delete();
         {m_ext, m_brk, m_shift, m_ctrl, m_alt, m_caps, m_ovf} = '0;
         m_idle = 0;
      end else begin
         push = (pipe.size() > 0) && (pipe[0].due == ecount);
         pop  = ren && (mq.size() > 0);
         drop = push && (mq.size() == DEPTH) && !pop;
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (!drop) mq.push_back(pipe[0].ev);
            void'(pipe.pop_front());
         end
         if (drop)         m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         if (byte_valid) begin
            m_idle = 0;
            model_byte(byte_data);
         end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_ext  = 1'b0;
               m_brk  = 1'b0;
               m_idle = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("data", data, (mq.size() > 0) ? mq[0] : 16'h0000);
         check("ready", {15'd0, ready}, {15'd0, mq.size() > 0});
         check("overflow", {15'd0, overflow}, {15'd0, m_ovf});
         check("caps_led", {15'd0, caps_led}, {15'd0, m_caps});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
      byte_valid = v;
      byte_data  = d;
      ren        = r;
      clr_ovf    = c;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      ren        = 1'b0;
      clr_ovf    = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      cyc(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic expect_pop(input string name, input logic [15:0] exp);
      int i = 0;
      while (!ready && i < 8) begin
         idle(1);
         i++;
      end
      check({name, "_ready"}, {15'd0, ready}, 16'h0001);
      check(name, data, exp);
      check({name, "_model"}, (mq.size() > 0) ? mq[0] : 16'h0000, exp);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      logic [7:0] mods [5] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
      logic [7:0] igns [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
      init_tables();
      do_reset();
      chk_en = 1'b1;
      check("rst_data", data, 16'h0000);
      check("rst_ready", {15'd0, ready}, 16'h0000);
      check("rst_ovf", {15'd0, overflow}, 16'h0000);
      check("rst_caps", {15'd0, caps_led}, 16'h0000);

      // basic make and pipeline latency
      send(8'h1C);
      check("lat_n1", {15'd0, ready}, 16'h0000);
      idle(1);
      check("lat_n2", {15'd0, ready}, 16'h0000);
      idle(1);
      check("lat_n3", {15'd0, ready}, 16'h0001);
      check("lat_data", data, 16'h0061);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("pop_data", data, 16'h0000);
      check("pop_ready", {15'd0, ready}, 16'h0000);

      // shift held around a key, then released
      do_reset();
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
      expect_pop("shift_make", 16'h0841);
      expect_pop("shift_break", 16'h8841);
      expect_pop("unshift", 16'h0061);

      // caps lock toggling
      do_reset();
      send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
      expect_pop("caps_a", 16'h0441);
      check("caps_on", {15'd0, caps_led}, 16'h0001);
      send(8'h58); send(8'hF0); send(8'h58);
      idle(1);
      check("caps_off", {15'd0, caps_led}, 16'h0000);

      // extended keys and timeout boundary
      do_reset();
      send(8'hE0); send(8'h75);
      expect_pop("ext_make", 16'h4275);
      send(8'hE0); send(8'hF0); send(8'h75);
      expect_pop("ext_break", 16'hC275);
      send(8'hE0); idle(TIMEOUT); send(8'h1C);
      expect_pop("timeout", 16'h0061);
      send(8'hE0); idle(TIMEOUT - 1); send(8'h1C);
      expect_pop("no_timeout", 16'h421C);

      // overflow and full push+pop
      do_reset();
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      idle(4);
      check("ovf_set", {15'd0, overflow}, 16'h0001);
      expect_pop("fifo0", 16'h0061);
      expect_pop("fifo1", 16'h0062);
      expect_pop("fifo2", 16'h0063);
      expect_pop("fifo3", 16'h0064);
      check("fifo_empty", {15'd0, ready}, 16'h0000);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", {15'd0, overflow}, 16'h0000);
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
      idle(3);
      send(8'h24); idle(1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      idle(1);
      check("full_pushpop_ovf", {15'd0, overflow}, 16'h0000);
      expect_pop("fp0", 16'h0062);
      expect_pop("fp1", 16'h0063);
      expect_pop("fp2", 16'h0064);
      expect_pop("fp3", 16'h0065);

      // reset mid-prefix, ignored bytes
      send(8'hF0);
      do_reset();
      send(8'h1C);
      expect_pop("after_rst", 16'h0061);
      send(8'hAA); send(8'hFA);
      idle(5);
      check("ignored", {15'd0, ready}, 16'h0000);

      // randomized traffic
      for (int k = 0; k < 2500; k++) begin
         logic [7:0] b;
         bit v, r, c;
         case ($urandom_range(0, 9))
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            2:       b = mods[$urandom_range(0, 4)];
            3:       b = igns[$urandom_range(0, 5)];
            9:       b = 8'($urandom);
            default: b = key_codes[$urandom_range(0, key_codes.size() - 1)];
         endcase
         v = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 35);
         c = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 999) == 0)      do_reset();
         else if ($urandom_range(0, 99) == 0)  idle(TIMEOUT - 1 + $urandom_range(0, 2));
         else                                  cyc(v, b, r, c);
      end
      idle(10);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
